// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side packer.
// Holds the default geometry and the packer FSM state encoding.
package fifo_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PACK    = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef logic [0:0] state_t;

    localparam state_t FILL = 1'b0;
    localparam state_t HOLD = 1'b1;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed output beat, bundled for the packer boundary.
// The master side is the packer: it drives the pop strobe and the output beat.
interface fifo_rd_packer_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PACK  = DEF_PACK
);
    logic                    fifo_empty;
    logic [WIDTH-1:0]        fifo_rdata;
    logic                    fifo_read;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH*PACK-1:0]   out_data;
    logic [PACK-1:0]         out_keep;

    modport master (
        input  fifo_empty, fifo_rdata, flush, out_ready,
        output fifo_read, out_valid, out_data, out_keep
    );

    modport slave (
        output fifo_empty, fifo_rdata, flush, out_ready,
        input  fifo_read, out_valid, out_data, out_keep
    );
endinterface

// File: rtl/pack_lane_reg.sv
// One WIDTH-bit lane of the output beat; load wins over clear.
// Single-cycle update, no handshake of its own.
module pack_lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (ld) begin
            data_d = d;
        end else if (clr) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;
endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK fall-through FIFO words into one beat; beat valid on the edge of the last pop.
// Stalls popping while a beat is held and out_ready is low; flush/timeout emit partial beats.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PACK    = DEF_PACK,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 3,
    parameter int TO_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    fifo_rd_packer_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [TO_W-1:0]         idle_q, idle_d;
    logic [PACK-1:0]         keep_q, keep_d;
    logic [PACK-1:0]         lane_ld;
    logic                    lane_clr;
    logic                    accept;
    logic                    pop;
    logic [WIDTH*PACK-1:0]   data_w;

    // Accepting a held beat frees the lanes in the same cycle, so popping continues.
    assign accept = (state_q == HOLD) && bus.out_ready;
    assign pop    = !bus.fifo_empty && !reset && ((state_q == FILL) || accept);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idle_d   = '0;
        keep_d   = keep_q;
        lane_ld  = '0;
        lane_clr = 1'b0;
        if (state_q == FILL) begin
            if (pop) begin
                for (int k = 0; k < PACK; k++) begin
                    if (count_q == CNT_W'(k)) begin
                        lane_ld[k] = 1'b1;
                    end
                end
                keep_d  = keep_q | lane_ld;
                count_d = count_q + 1'b1;
            end
            if (pop && (count_q == CNT_LAST)) begin
                state_d = HOLD;
            end else if (bus.flush && ((count_q != '0) || pop)) begin
                state_d = HOLD;
            end else if ((TIMEOUT != 0) && (count_q != '0) && !pop && (idle_q == TO_LAST)) begin
                state_d = HOLD;
            end else if ((count_q != '0) && !pop) begin
                idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
            end
        end else if (accept) begin
            state_d  = FILL;
            lane_clr = 1'b1;
            count_d  = '0;
            keep_d   = '0;
            if (pop) begin
                lane_ld[0] = 1'b1;
                keep_d[0]  = 1'b1;
                count_d    = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            count_q <= '0;
            idle_q  <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            keep_q  <= keep_d;
        end
    end

    for (genvar k = 0; k < PACK; k++) begin : g_lane
        pack_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .ld    (lane_ld[k]),
            .clr   (lane_clr),
            .d     (bus.fifo_rdata),
            .q     (data_w[k*WIDTH +: WIDTH])
        );
    end

    assign bus.fifo_read = pop;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_w;
    assign bus.out_keep  = keep_q;
endmodule
